// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// counter saturation value, default reset PC and an alignment helper.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [31:0] CNT_SAT          = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit saturating incrementer with async active-low clear; sticks at
// CNT_SAT instead of wrapping.
module sat_counter
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= '0;
    else if (inc_i && cnt_q != CNT_SAT) cnt_q <= cnt_q + 32'd1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC holder and run/halt/step controller feeding a single-cycle core.
// Optional breakpoint logic is built when PC_BREAKPOINT_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter logic        SELF_LOOP_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_addr_i,
  output logic [31:0] pc_o,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        halt_req_i,
  output logic        exec_en_o,
  output logic [2:0]  state_o,
  output logic [31:0] retired_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
`ifdef PC_BREAKPOINT_EN
  ,
  input  logic [31:0] bp_addr_i,
  input  logic        bp_valid_i,
  output logic        bp_hit_o
`endif
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fault_addr_q;
  logic        fault_q;
  logic        step_q;
  logic        step_go;
  logic        bp_block;
  logic        idle_like;

  // A held step must be released before it can trigger another instruction.
  assign step_go   = step_i && !step_q;
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALT);

`ifdef PC_BREAKPOINT_EN
  logic bp_hit_q;
  logic bp_skip_q;

  assign bp_block = (state_q == ST_RUN) && bp_valid_i && (pc_q == bp_addr_i) && !bp_skip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      if (idle_like && (start_i || step_go)) bp_hit_q <= 1'b0;
      else if (bp_block)                     bp_hit_q <= 1'b1;
      // Lets a resume from HALT execute the instruction sitting on the breakpoint.
      bp_skip_q <= (state_q == ST_HALT) && start_i;
    end
  end

  assign bp_hit_o = bp_hit_q;
`else
  assign bp_block = 1'b0;
`endif

  assign exec_en_o = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_block;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      step_q       <= 1'b0;
    end else begin
      step_q <= step_i;
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start_i)      state_q <= ST_RUN;
          else if (step_go) state_q <= ST_STEP;
        end
        ST_RUN, ST_STEP: begin
          if (bp_block) begin
            state_q <= ST_HALT;
          end else if (misaligned(next_addr_i)) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_addr_q <= next_addr_i;
          end else begin
            pc_q <= next_addr_i;
            if (state_q == ST_STEP || halt_req_i ||
                (SELF_LOOP_HALT && next_addr_i == pc_q))
              state_q <= ST_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (exec_en_o),
    .cnt_o (retired_o)
  );

  assign pc_o         = pc_q;
  assign state_o      = state_q;
  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run compared against a transaction-level model of the run-control rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_addr = '0;
  logic        start = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic [31:0] pc_o, retired_o, fault_addr_o;
  logic        exec_en_o, fault_o;
  logic [2:0]  state_o;
`ifdef PC_BREAKPOINT_EN
  logic [31:0] bp_addr = '0;
  logic        bp_valid = 1'b0;
  logic        bp_hit_o;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0), .SELF_LOOP_HALT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .next_addr_i(next_addr), .pc_o(pc_o),
    .start_i(start), .step_i(step), .halt_req_i(halt_req),
    .exec_en_o(exec_en_o), .state_o(state_o), .retired_o(retired_o),
    .fault_o(fault_o), .fault_addr_o(fault_addr_o)
`ifdef PC_BREAKPOINT_EN
    , .bp_addr_i(bp_addr), .bp_valid_i(bp_valid), .bp_hit_o(bp_hit_o)
`endif
  );

  // Reference model: states as plain ints 0..4 (IDLE,RUN,STEP,HALT,FAULT).
  int          m_st;
  logic [31:0] m_pc, m_ret, m_faddr;
  bit          m_fault, m_step_prev;

  function automatic bit m_exec();
    return (m_st == 1) || (m_st == 2);
  endfunction

  task automatic m_reset();
    m_st = 0; m_pc = 32'h0; m_ret = 0; m_faddr = 0; m_fault = 0; m_step_prev = 0;
  endtask

  task automatic m_clock();
    bit commit    = m_exec();
    bit new_step  = step && !m_step_prev;
    m_step_prev   = step;
    if (commit && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
    if (m_st == 0 || m_st == 3) begin
      if (start) m_st = 1;
      else if (new_step) m_st = 2;
    end else if (commit) begin
      if (next_addr % 4 != 0) begin
        m_st = 4; m_fault = 1; m_faddr = next_addr;
      end else begin
        if (m_st == 2 || halt_req || next_addr == m_pc) m_st = 3;
        m_pc = next_addr;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; step = 0; halt_req = 0; next_addr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h exp %h", pc_o, 32'h0); end
    n_chk++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d exp 0", state_o); end
    n_chk++; if (exec_en_o !== 1'b0) begin n_err++; $display("FAIL reset_exec_en: got %b exp 0", exec_en_o); end
    n_chk++; if (retired_o !== 32'h0) begin n_err++; $display("FAIL reset_retired: got %0d exp 0", retired_o); end
    n_chk++; if (fault_o !== 1'b0 || fault_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_fault: got %b/%h exp 0/0", fault_o, fault_addr_o); end
  endtask

  task automatic test_run_seq();
    logic [31:0] exp_pc;
    do_reset();
    start = 1;
    @(posedge clk); #1; start = 0;
    n_chk++; if (state_o !== 3'd1 || exec_en_o !== 1'b1 || pc_o !== 32'h0) begin n_err++; $display("FAIL run_start: got st=%0d en=%b pc=%h exp 1/1/0", state_o, exec_en_o, pc_o); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      next_addr = exp_pc + 32'd4;
      @(posedge clk); #1;
      exp_pc = exp_pc + 32'd4;
      n_chk++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL run_pc%0d: got %h exp %h", i, pc_o, exp_pc); end
    end
    n_chk++; if (retired_o !== 32'd3) begin n_err++; $display("FAIL run_retired: got %0d exp 3", retired_o); end
    halt_req = 1; next_addr = 32'h10;
    @(posedge clk); #1; halt_req = 0;
    n_chk++; if (state_o !== 3'd3 || pc_o !== 32'h10 || exec_en_o !== 1'b0 || retired_o !== 32'd4) begin
      n_err++; $display("FAIL run_halt_req: got st=%0d pc=%h en=%b ret=%0d exp 3/10/0/4", state_o, pc_o, exec_en_o, retired_o); end
  endtask

  task automatic test_self_loop();
    do_reset();
    start = 1;
    @(posedge clk); #1; start = 0;
    for (int i = 0; i < 4; i++) begin
      next_addr = 32'(4 * (i + 1));
      @(posedge clk); #1;
    end
    next_addr = 32'h10;
    @(posedge clk); #1;
    n_chk++; if (state_o !== 3'd3) begin n_err++; $display("FAIL self_loop_state: got %0d exp 3", state_o); end
    n_chk++; if (pc_o !== 32'h10) begin n_err++; $display("FAIL self_loop_pc: got %h exp %h", pc_o, 32'h10); end
    n_chk++; if (exec_en_o !== 1'b0 || retired_o !== 32'd5) begin n_err++; $display("FAIL self_loop_en_ret: got %b/%0d exp 0/5", exec_en_o, retired_o); end
  endtask

  // Runs from the HALT state left by test_self_loop.
  task automatic test_step();
    int commits = 0;
    step = 1; next_addr = 32'h14;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) step = 0;
      if (exec_en_o === 1'b1) commits++;
    end
    n_chk++; if (commits != 1) begin n_err++; $display("FAIL step_commits: got %0d exp 1", commits); end
    n_chk++; if (retired_o !== 32'd6 || pc_o !== 32'h14 || state_o !== 3'd3) begin
      n_err++; $display("FAIL step_result: got ret=%0d pc=%h st=%0d exp 6/14/3", retired_o, pc_o, state_o); end
  endtask

  task automatic test_fault();
    do_reset();
    start = 1;
    @(posedge clk); #1; start = 0; next_addr = 32'h4;
    @(posedge clk); #1; next_addr = 32'h22;
    n_chk++; if (exec_en_o !== 1'b1) begin n_err++; $display("FAIL fault_commit_en: got %b exp 1", exec_en_o); end
    @(posedge clk); #1;
    n_chk++; if (state_o !== 3'd4 || fault_o !== 1'b1 || fault_addr_o !== 32'h22) begin
      n_err++; $display("FAIL fault_capture: got st=%0d f=%b fa=%h exp 4/1/22", state_o, fault_o, fault_addr_o); end
    n_chk++; if (pc_o !== 32'h4 || exec_en_o !== 1'b0 || retired_o !== 32'd2) begin
      n_err++; $display("FAIL fault_freeze: got pc=%h en=%b ret=%0d exp 4/0/2", pc_o, exec_en_o, retired_o); end
    start = 1; step = 1; next_addr = 32'h100;
    repeat (3) @(posedge clk); #1;
    start = 0; step = 0;
    n_chk++; if (state_o !== 3'd4 || pc_o !== 32'h4 || retired_o !== 32'd2) begin
      n_err++; $display("FAIL fault_terminal: got st=%0d pc=%h ret=%0d exp 4/4/2", state_o, pc_o, retired_o); end
    #1; rst_n = 0; #1;
    n_chk++; if (state_o !== 3'd0 || pc_o !== 32'h0 || fault_o !== 1'b0 || fault_addr_o !== 32'h0 || retired_o !== 32'h0) begin
      n_err++; $display("FAIL fault_reset: got st=%0d pc=%h f=%b fa=%h ret=%0d exp all 0", state_o, pc_o, fault_o, fault_addr_o, retired_o); end
    @(negedge clk); rst_n = 1; m_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1;
    @(posedge clk); #1; start = 0;
    for (int i = 0; i < 16; i++) begin
      next_addr = 32'(4 * (i + 1));
      @(posedge clk); #1;
    end
    n_chk++; if (pc_o !== 32'h40 || state_o !== 3'd1) begin n_err++; $display("FAIL async_pre: got pc=%h st=%0d exp 40/1", pc_o, state_o); end
    #2; rst_n = 0; #1;
    n_chk++; if (pc_o !== 32'h0 || state_o !== 3'd0 || exec_en_o !== 1'b0 || retired_o !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got pc=%h st=%0d en=%b ret=%0d exp 0/0/0/0", pc_o, state_o, exec_en_o, retired_o); end
    @(negedge clk); rst_n = 1; m_reset();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_chk++; if (pc_o !== m_pc) begin n_err++; $display("FAIL rand_pc cyc %0d: got %h exp %h", cyc, pc_o, m_pc); end
      n_chk++; if (state_o !== 3'(m_st)) begin n_err++; $display("FAIL rand_state cyc %0d: got %0d exp %0d", cyc, state_o, m_st); end
      n_chk++; if (retired_o !== m_ret) begin n_err++; $display("FAIL rand_retired cyc %0d: got %0d exp %0d", cyc, retired_o, m_ret); end
      n_chk++; if (exec_en_o !== m_exec()) begin n_err++; $display("FAIL rand_exec_en cyc %0d: got %b exp %b", cyc, exec_en_o, m_exec()); end
      n_chk++; if (fault_o !== m_fault || fault_addr_o !== m_faddr) begin
        n_err++; $display("FAIL rand_fault cyc %0d: got %b/%h exp %b/%h", cyc, fault_o, fault_addr_o, m_fault, m_faddr); end
      if (m_st == 4 && $urandom_range(0, 7) == 0) begin
        do_reset();
        continue;
      end
      start    = ($urandom_range(0, 7) == 0);
      step     = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 63);
      if (r == 0)       next_addr = m_pc + 32'($urandom_range(1, 3));
      else if (r < 6)   next_addr = m_pc;
      else if (r < 10)  next_addr = $urandom & 32'hFFFF_FFFC;
      else              next_addr = m_pc + 32'd4;
      @(posedge clk);
      m_clock();
      @(negedge clk);
    end
  endtask

`ifdef PC_BREAKPOINT_EN
  task automatic test_breakpoint();
    do_reset();
    bp_addr = 32'h8; bp_valid = 1;
    start = 1;
    @(posedge clk); #1; start = 0;
    for (int i = 0; i < 10 && state_o !== 3'd3; i++) begin
      next_addr = pc_o + 32'd4;
      @(posedge clk); #1;
    end
    n_chk++; if (state_o !== 3'd3 || pc_o !== 32'h8) begin n_err++; $display("FAIL bp_halt: got st=%0d pc=%h exp 3/8", state_o, pc_o); end
    n_chk++; if (bp_hit_o !== 1'b1 || retired_o !== 32'd2) begin n_err++; $display("FAIL bp_hit: got %b ret=%0d exp 1/2", bp_hit_o, retired_o); end
    start = 1; next_addr = 32'hC;
    @(posedge clk); #1; start = 0;
    n_chk++; if (bp_hit_o !== 1'b0 || exec_en_o !== 1'b1) begin n_err++; $display("FAIL bp_resume: got hit=%b en=%b exp 0/1", bp_hit_o, exec_en_o); end
    @(posedge clk); #1;
    n_chk++; if (pc_o !== 32'hC || retired_o !== 32'd3) begin n_err++; $display("FAIL bp_past: got pc=%h ret=%0d exp c/3", pc_o, retired_o); end
    bp_valid = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_run_seq();
    test_self_loop();
    test_step();
    test_fault();
    test_async_reset();
`ifdef PC_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
